// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle RV32I control sequencer.
// Steps FETCH/DECODE/EXEC/MEM/WB and drives datapath enables per state.
// Ports: clk, rst (async, active-high); instr_opcode, br_taken,
//   imem_ready, dmem_ready in; imem_req, dmem_req, ir_write, pc_write,
//   pc_src, reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg,
//   wb_pc4 (control); state (debug); instret (retired count);
//   mem_timeout (sticky request timeout).
// Option: CTRL_ILLEGAL_TRAP_EN halts on unknown opcodes and adds the
//   sticky illegal output; otherwise unknown opcodes retire as NOPs.
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       instr_opcode,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             wb_pc4,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             mem_timeout
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [1:0] PC_4   = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_RS1 = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_UI  = 2'b11;

  // wait_cnt only needs to reach TIMEOUT_CYC-1
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYC > 0);
  localparam logic [WW-1:0] WAIT_LAST =
    WW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [2:0]       cur_state;
  logic [2:0]       nxt_state;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] cnt;
  logic             tmo_flag;

  logic is_r, is_i, is_lw, is_sw, is_jal;
  logic is_jalr, is_lui, is_auipc, is_br;
  logic is_wb_cls;

  logic       imem_req_c;
  logic       dmem_req_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic [1:0] pc_src_c;
  logic       reg_write_c;
  logic       alu_src_c;
  logic [1:0] alu_op_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       mem_to_reg_c;
  logic       wb_pc4_c;
  logic       retire;
  logic       req_wait;
  logic       tmo_hit;
  logic       set_illegal;

  assign is_r     = (instr_opcode == OP_R);
  assign is_i     = (instr_opcode == OP_I);
  assign is_lw    = (instr_opcode == OP_LW);
  assign is_sw    = (instr_opcode == OP_SW);
  assign is_jal   = (instr_opcode == OP_JAL);
  assign is_jalr  = (instr_opcode == OP_JALR);
  assign is_lui   = (instr_opcode == OP_LUI);
  assign is_auipc = (instr_opcode == OP_AUIPC);
  assign is_br    = (instr_opcode == OP_BR);

  // opcodes that finish through the register writeback state
  assign is_wb_cls = is_r | is_i | is_jal | is_jalr
                   | is_lui | is_auipc;

  // a request is waiting when it is up and its memory is not ready
  assign req_wait =
    ((cur_state == S_FETCH) && !imem_ready) ||
    ((cur_state == S_MEM) && !dmem_ready);

  // ready in the last allowed cycle wins, since req_wait excludes it
  assign tmo_hit = TMO_EN && req_wait && (wait_cnt == WAIT_LAST);

  always_comb begin
    nxt_state    = cur_state;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PC_4;
    reg_write_c  = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = ALU_ADD;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    wb_pc4_c     = 1'b0;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          nxt_state  = S_DECODE;
        end else if (tmo_hit) begin
          nxt_state = S_HALT;
        end
      end
      S_DECODE: begin
        nxt_state = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_r: begin
            alu_op_c  = ALU_R;
            alu_src_c = 1'b0;
          end
          is_i, is_lw, is_sw, is_jal, is_jalr: begin
            alu_op_c  = ALU_ADD;
            alu_src_c = 1'b1;
          end
          is_lui, is_auipc: begin
            alu_op_c  = ALU_UI;
            alu_src_c = 1'b1;
          end
          is_br: begin
            alu_op_c  = ALU_BR;
            alu_src_c = 1'b0;
          end
          default: begin
            alu_op_c  = ALU_ADD;
            alu_src_c = 1'b0;
          end
        endcase
        unique case (1'b1)
          is_lw, is_sw: begin
            nxt_state = S_MEM;
          end
          is_br: begin
            pc_write_c = 1'b1;
            pc_src_c   = br_taken ? PC_IMM : PC_4;
            retire     = 1'b1;
            nxt_state  = S_FETCH;
          end
          is_wb_cls: begin
            nxt_state = S_WB;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            set_illegal = 1'b1;
            nxt_state   = S_HALT;
`else
            pc_write_c = 1'b1;
            pc_src_c   = PC_4;
            retire     = 1'b1;
            nxt_state  = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        dmem_req_c  = 1'b1;
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            pc_write_c = 1'b1;
            pc_src_c   = PC_4;
            retire     = 1'b1;
            nxt_state  = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end else if (tmo_hit) begin
          nxt_state = S_HALT;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = is_lw;
        wb_pc4_c     = is_jal | is_jalr;
        pc_write_c   = 1'b1;
        pc_src_c     = is_jal  ? PC_IMM :
                       is_jalr ? PC_RS1 : PC_4;
        retire       = 1'b1;
        nxt_state    = S_FETCH;
      end
      S_HALT: begin
        nxt_state = S_HALT;
      end
      default: begin
        nxt_state = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      cnt       <= '0;
      tmo_flag  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (retire)
        cnt <= cnt + CNT_W'(1);
      if (tmo_hit)
        tmo_flag <= 1'b1;
      if ((nxt_state != cur_state) &&
          ((nxt_state == S_FETCH) || (nxt_state == S_MEM)))
        wait_cnt <= '0;
      else if (req_wait)
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ill_flag <= 1'b0;
    else if (set_illegal)
      ill_flag <= 1'b1;
  end

  assign illegal = ill_flag & ~rst;
`endif

  // outputs are forced low for as long as rst is held
  assign imem_req    = imem_req_c & ~rst;
  assign dmem_req    = dmem_req_c & ~rst;
  assign ir_write    = ir_write_c & ~rst;
  assign pc_write    = pc_write_c & ~rst;
  assign pc_src      = rst ? 2'b00 : pc_src_c;
  assign reg_write   = reg_write_c & ~rst;
  assign alu_src     = alu_src_c & ~rst;
  assign alu_op      = rst ? 2'b00 : alu_op_c;
  assign mem_read    = mem_read_c & ~rst;
  assign mem_write   = mem_write_c & ~rst;
  assign mem_to_reg  = mem_to_reg_c & ~rst;
  assign wb_pc4      = wb_pc4_c & ~rst;
  assign state       = rst ? 3'd0 : cur_state;
  assign instret     = rst ? '0 : cnt;
  assign mem_timeout = tmo_flag & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle expected control vectors are
// queued from an instruction table and compared as the DUT steps.
module tb_multicycle_ctrl_fsm;

  localparam int TCYC = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    instr_opcode = '0;
  logic          br_taken = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          imem_req, dmem_req, ir_write, pc_write;
  logic [1:0]    pc_src;
  logic          reg_write, alu_src;
  logic [1:0]    alu_op;
  logic          mem_read, mem_write, mem_to_reg, wb_pc4;
  logic [2:0]    state;
  logic [CW-1:0] instret;
  logic          mem_timeout;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic          illegal;
`endif

  multicycle_ctrl_fsm #(
    .TIMEOUT_CYC(TCYC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instr_opcode(instr_opcode),
    .br_taken(br_taken),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .imem_req(imem_req),
    .dmem_req(dmem_req),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .reg_write(reg_write),
    .alu_src(alu_src),
    .alu_op(alu_op),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_to_reg(mem_to_reg),
    .wb_pc4(wb_pc4),
    .state(state),
    .instret(instret),
    .mem_timeout(mem_timeout)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       dmem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       wb_pc4;
    logic       mem_timeout;
  } ctl_t;

  typedef struct {
    ctl_t  exp;
    logic  ir;
    logic  dr;
    string tag;
  } sb_t;

  typedef enum {P_WB, P_LD, P_ST, P_BR, P_NOP} path_e;

  typedef struct {
    logic [6:0] op;
    logic       br;
    int         iw;
    int         dw;
    logic [1:0] aop;
    logic       asrc;
    path_e      path;
    logic [1:0] psrc;
    logic       pc4;
    string      name;
  } vec_t;

  localparam int NV = 14;

  vec_t          vt [NV];
  sb_t           sbq [$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_instret = '0;

  function automatic vec_t mk(
    input logic [6:0] op, input logic br, input int iw, input int dw,
    input logic [1:0] aop, input logic asrc, input path_e path,
    input logic [1:0] psrc, input logic pc4, input string name);
    vec_t v;
    v.op = op; v.br = br; v.iw = iw; v.dw = dw;
    v.aop = aop; v.asrc = asrc; v.path = path;
    v.psrc = psrc; v.pc4 = pc4; v.name = name;
    return v;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.state = state;
    c.imem_req = imem_req;
    c.dmem_req = dmem_req;
    c.ir_write = ir_write;
    c.pc_write = pc_write;
    c.pc_src = pc_src;
    c.reg_write = reg_write;
    c.alu_src = alu_src;
    c.alu_op = alu_op;
    c.mem_read = mem_read;
    c.mem_write = mem_write;
    c.mem_to_reg = mem_to_reg;
    c.wb_pc4 = wb_pc4;
    c.mem_timeout = mem_timeout;
    return c;
  endfunction

  task automatic check_ctl(input string tag, input ctl_t act,
                           input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (state,ireq,dreq,irw,pcw,pcsrc,rw,asrc,aop,mr,mw,m2r,pc4,tmo)",
               tag, act, exp);
    end
  endtask

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic push(input ctl_t e, input logic ir, input logic dr,
                      input string tag);
    sb_t s;
    s.exp = e; s.ir = ir; s.dr = dr; s.tag = tag;
    sbq.push_back(s);
  endtask

  task automatic push_fetch_wait(input int n, input string tag);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.imem_req = 1'b1;
      push(c, 1'b0, 1'b0, {tag, "/fetch_wait"});
    end
  endtask

  task automatic push_fetch_done(input string tag);
    ctl_t c = '0;
    c.imem_req = 1'b1;
    c.ir_write = 1'b1;
    push(c, 1'b1, 1'b0, {tag, "/fetch"});
  endtask

  task automatic push_decode(input string tag);
    ctl_t c = '0;
    c.state = 3'd1;
    push(c, 1'b0, 1'b0, {tag, "/decode"});
  endtask

  task automatic push_exec(input logic [1:0] aop, input logic asrc,
                           input logic pcw, input logic [1:0] psrc,
                           input string tag);
    ctl_t c = '0;
    c.state = 3'd2;
    c.alu_op = aop;
    c.alu_src = asrc;
    c.pc_write = pcw;
    c.pc_src = psrc;
    push(c, 1'b0, 1'b0, {tag, "/exec"});
  endtask

  task automatic push_mem_wait(input logic ld, input int n,
                               input string tag);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.state = 3'd3;
      c.dmem_req = 1'b1;
      c.mem_read = ld;
      c.mem_write = ~ld;
      push(c, 1'b0, 1'b0, {tag, "/mem_wait"});
    end
  endtask

  task automatic push_mem_done(input logic ld, input string tag);
    ctl_t c = '0;
    c.state = 3'd3;
    c.dmem_req = 1'b1;
    c.mem_read = ld;
    c.mem_write = ~ld;
    c.pc_write = ~ld;
    push(c, 1'b0, 1'b1, {tag, "/mem"});
  endtask

  task automatic push_wb(input logic ld, input logic [1:0] psrc,
                         input logic pc4, input string tag);
    ctl_t c = '0;
    c.state = 3'd4;
    c.reg_write = 1'b1;
    c.pc_write = 1'b1;
    c.pc_src = psrc;
    c.mem_to_reg = ld;
    c.wb_pc4 = pc4;
    push(c, 1'b0, 1'b0, {tag, "/wb"});
  endtask

  task automatic push_halt(input int n, input logic tmo,
                           input string tag);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.state = 3'd5;
      c.mem_timeout = tmo;
      push(c, 1'b1, 1'b1, {tag, "/halt"});
    end
  endtask

  task automatic build(input vec_t v);
    logic pcw_ex;
    pcw_ex = (v.path == P_BR) || (v.path == P_NOP);
    push_fetch_wait(v.iw, v.name);
    push_fetch_done(v.name);
    push_decode(v.name);
    push_exec(v.aop, v.asrc, pcw_ex, pcw_ex ? v.psrc : 2'b00, v.name);
    if (v.path == P_LD || v.path == P_ST) begin
      push_mem_wait(v.path == P_LD, v.dw, v.name);
      push_mem_done(v.path == P_LD, v.name);
    end
    if (v.path == P_LD || v.path == P_WB)
      push_wb(v.path == P_LD, v.psrc, v.pc4, v.name);
    exp_instret = exp_instret + 1'b1;
  endtask

  // one queue entry per clock: drive readies, then compare outputs
  task automatic drain();
    sb_t s;
    while (sbq.size() > 0) begin
      @(negedge clk);
      s = sbq.pop_front();
      imem_ready = s.ir;
      dmem_ready = s.dr;
      #1;
      check_ctl(s.tag, sample(), s.exp);
      @(posedge clk);
    end
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    instr_opcode = v.op;
    br_taken = v.br;
    build(v);
    drain();
    check_val({v.name, "/instret"}, int'(instret), int'(exp_instret));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check_ctl({tag, "/rst_outputs"}, sample(), '0);
    check_val({tag, "/rst_instret"}, int'(instret), 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_val({tag, "/rst_illegal"}, int'(illegal), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    exp_instret = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(7'b0010011, 0, 2, 0, 2'b00, 1, P_WB, 2'b00, 0, "addi");
    vt[1]  = mk(7'b0000011, 0, 0, 0, 2'b00, 1, P_LD, 2'b00, 0, "lw");
    vt[2]  = mk(7'b0100011, 0, 0, 0, 2'b00, 1, P_ST, 2'b00, 0, "sw");
    vt[3]  = mk(7'b1100011, 1, 0, 0, 2'b01, 0, P_BR, 2'b01, 0, "beq_t");
    vt[4]  = mk(7'b1100011, 0, 0, 0, 2'b01, 0, P_BR, 2'b00, 0, "beq_nt");
    vt[5]  = mk(7'b1100111, 0, 0, 0, 2'b00, 1, P_WB, 2'b10, 1, "jalr");
    vt[6]  = mk(7'b1101111, 0, 0, 0, 2'b00, 1, P_WB, 2'b01, 1, "jal");
    vt[7]  = mk(7'b0110011, 0, 0, 0, 2'b10, 0, P_WB, 2'b00, 0, "rtype");
    vt[8]  = mk(7'b0110111, 0, 0, 0, 2'b11, 1, P_WB, 2'b00, 0, "lui");
    vt[9]  = mk(7'b0010111, 0, 0, 0, 2'b11, 1, P_WB, 2'b00, 0, "auipc");
    vt[10] = mk(7'b0000011, 0, 3, 3, 2'b00, 1, P_LD, 2'b00, 0, "lw_edge");
    vt[11] = mk(7'b0100011, 0, 1, 2, 2'b00, 1, P_ST, 2'b00, 0, "sw_wait");
    vt[12] = mk(7'b0110011, 1, 1, 0, 2'b10, 0, P_WB, 2'b00, 0, "rtype_w");
`ifdef CTRL_ILLEGAL_TRAP_EN
    vt[13] = mk(7'b1100011, 1, 3, 0, 2'b01, 0, P_BR, 2'b01, 0, "beq_w");
`else
    vt[13] = mk(7'b1111111, 0, 0, 0, 2'b00, 0, P_NOP, 2'b00, 0, "nop_ill");
`endif

    do_reset("init");

    for (int i = 0; i < NV; i++)
      run_vec(vt[i]);

    // counter is CW bits wide, so this crosses the wrap point
    for (int k = 0; k < 20; k++)
      run_vec(vt[k % 2 == 0 ? 3 : 4]);

    // reset in the middle of a stalled store
    instr_opcode = 7'b0100011;
    br_taken = 1'b0;
    push_fetch_done("sw_abort");
    push_decode("sw_abort");
    push_exec(2'b00, 1'b1, 1'b0, 2'b00, "sw_abort");
    push_mem_wait(1'b0, 2, "sw_abort");
    drain();
    do_reset("sw_abort");
    run_vec(vt[0]);

    // data memory timeout on a load
    instr_opcode = 7'b0000011;
    push_fetch_done("lw_tmo");
    push_decode("lw_tmo");
    push_exec(2'b00, 1'b1, 1'b0, 2'b00, "lw_tmo");
    push_mem_wait(1'b1, TCYC, "lw_tmo");
    push_halt(3, 1'b1, "lw_tmo");
    drain();
    check_val("lw_tmo/instret", int'(instret), int'(exp_instret));
    do_reset("lw_tmo");

    // instruction memory timeout
    instr_opcode = 7'b0010011;
    push_fetch_wait(TCYC, "if_tmo");
    push_halt(2, 1'b1, "if_tmo");
    drain();
    check_val("if_tmo/instret", int'(instret), 0);
    do_reset("if_tmo");
    run_vec(vt[2]);

`ifdef CTRL_ILLEGAL_TRAP_EN
    instr_opcode = 7'b1111111;
    push_fetch_done("trap");
    push_decode("trap");
    push_exec(2'b00, 1'b0, 1'b0, 2'b00, "trap");
    push_halt(2, 1'b0, "trap");
    drain();
    check_val("trap/illegal", int'(illegal), 1);
    check_val("trap/instret", int'(instret), int'(exp_instret));
    do_reset("trap");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
